// File: rtl/output_shift_ctrl_pkg.sv
// rtl/output_shift_ctrl_pkg.sv - shared types and constants for the output shift controller
package output_ctrl_pkg;

  localparam int SHIFT_W_DEFAULT = 4;
  localparam int HOLD_W_DEFAULT  = 16;
  localparam int MAX_SHIFT       = (1 << SHIFT_W_DEFAULT) - 1;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PENDING    = 2'd1,
    SWEEP_WAIT = 2'd2,
    SWEEP_HOLD = 2'd3
  } state_t;

endpackage

// File: rtl/output_shift_ctrl_if.sv
// rtl/output_shift_ctrl_if.sv - host shift-request valid/ready handshake bundle
interface output_shift_ctrl_if
  import output_ctrl_pkg::*;
#(
  parameter int SHIFT_W = SHIFT_W_DEFAULT
);
  logic               host_shift_valid;
  logic               host_shift_ready;
  logic [SHIFT_W-1:0] host_shift_data;

  modport master (
    output host_shift_valid,
    output host_shift_data,
    input  host_shift_ready
  );

  modport slave (
    input  host_shift_valid,
    input  host_shift_data,
    output host_shift_ready
  );
endinterface

// File: rtl/output_shift_ctrl_hold_counter.sv
// rtl/output_shift_ctrl_hold_counter.sv - frame-advanced loadable down-counter for sweep step holds
module frame_hold_counter
  import output_ctrl_pkg::*;
#(
  parameter int HOLD_W = HOLD_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [HOLD_W-1:0] load_val,
  input  logic              advance,
  output logic              is_one
);

  logic [HOLD_W-1:0] count;

  // Load wins over advance so a step boundary reloads instead of decrementing
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (advance && (count != '0)) begin
      count <= count - HOLD_W'(1);
    end
  end

  assign is_one = (count == HOLD_W'(1));

endmodule

// File: rtl/output_shift_ctrl.sv
// rtl/output_shift_ctrl.sv - frame-aligned shift_amt owner with host updates and calibration sweep
module output_shift_ctrl
  import output_ctrl_pkg::*;
#(
  parameter int SHIFT_W = SHIFT_W_DEFAULT,
  parameter int HOLD_W  = HOLD_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_start,
  output_shift_ctrl_if.slave host,
  input  logic               sweep_start,
  input  logic [HOLD_W-1:0]  sweep_hold,
  input  logic               sweep_abort,
  output logic [SHIFT_W-1:0] shift_amt,
  output logic               shift_update,
  output logic               sweep_active,
  output logic [SHIFT_W-1:0] sweep_step,
  output logic               sweep_done
);

  localparam logic [SHIFT_W-1:0] STEP_MAX = {SHIFT_W{1'b1}};
  localparam logic [HOLD_W-1:0]  HOLD_ONE = HOLD_W'(1);

  state_t             state, state_nx;
  logic [SHIFT_W-1:0] pend, pend_nx;
  logic [SHIFT_W-1:0] saved, saved_nx;
  logic [HOLD_W-1:0]  hold, hold_nx;
  logic [SHIFT_W-1:0] shift_nx, step_nx;
  logic               update_nx, active_nx, done_nx;
  logic               ready;
  logic               cnt_load, cnt_adv, cnt_is_one;

  assign ready                 = (state == IDLE) && !sweep_start && !rst;
  assign host.host_shift_ready = ready;
  assign cnt_adv               = frame_start && (state == SWEEP_HOLD);

  frame_hold_counter #(
    .HOLD_W (HOLD_W)
  ) u_hold_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (hold),
    .advance  (cnt_adv),
    .is_one   (cnt_is_one)
  );

  always_comb begin
    state_nx  = state;
    pend_nx   = pend;
    saved_nx  = saved;
    hold_nx   = hold;
    shift_nx  = shift_amt;
    step_nx   = sweep_step;
    update_nx = 1'b0;
    active_nx = sweep_active;
    done_nx   = 1'b0;
    cnt_load  = 1'b0;

    case (state)
      IDLE: begin
        if (sweep_start) begin
          hold_nx   = (sweep_hold == '0) ? HOLD_ONE : sweep_hold;
          saved_nx  = shift_amt;
          active_nx = 1'b1;
          step_nx   = '0;
          state_nx  = SWEEP_WAIT;
        end else if (host.host_shift_valid && ready) begin
          pend_nx  = host.host_shift_data;
          state_nx = PENDING;
        end
      end

      PENDING: begin
        if (frame_start) begin
          shift_nx  = pend;
          update_nx = 1'b1;
          state_nx  = IDLE;
        end
      end

      SWEEP_WAIT: begin
        if (sweep_abort) begin
          shift_nx  = saved;
          update_nx = 1'b1;
          active_nx = 1'b0;
          step_nx   = '0;
          state_nx  = IDLE;
        end else if (frame_start) begin
          shift_nx  = '0;
          step_nx   = '0;
          update_nx = 1'b1;
          cnt_load  = 1'b1;
          state_nx  = SWEEP_HOLD;
        end
      end

      SWEEP_HOLD: begin
        // Abort outranks a coincident step so the sweep never advances past it
        if (sweep_abort) begin
          shift_nx  = saved;
          update_nx = 1'b1;
          active_nx = 1'b0;
          step_nx   = '0;
          state_nx  = IDLE;
        end else if (frame_start && cnt_is_one) begin
          update_nx = 1'b1;
          if (sweep_step == STEP_MAX) begin
            shift_nx  = saved;
            done_nx   = 1'b1;
            active_nx = 1'b0;
            step_nx   = '0;
            state_nx  = IDLE;
          end else begin
            shift_nx = shift_amt + SHIFT_W'(1);
            step_nx  = sweep_step + SHIFT_W'(1);
            cnt_load = 1'b1;
          end
        end
      end

      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      pend         <= '0;
      saved        <= '0;
      hold         <= '0;
      shift_amt    <= '0;
      shift_update <= 1'b0;
      sweep_active <= 1'b0;
      sweep_step   <= '0;
      sweep_done   <= 1'b0;
    end else begin
      state        <= state_nx;
      pend         <= pend_nx;
      saved        <= saved_nx;
      hold         <= hold_nx;
      shift_amt    <= shift_nx;
      shift_update <= update_nx;
      sweep_active <= active_nx;
      sweep_step   <= step_nx;
      sweep_done   <= done_nx;
    end
  end

endmodule

// File: tb/tb_output_shift_ctrl.sv
// tb/tb_output_shift_ctrl.sv - randomized self-checking bench for output_shift_ctrl
module tb_output_shift_ctrl;
  import output_ctrl_pkg::*;

  localparam int SW = SHIFT_W_DEFAULT;
  localparam int HW = HOLD_W_DEFAULT;

  logic          clk = 1'b0;
  logic          rst;
  logic          frame_start;
  logic          sweep_start;
  logic [HW-1:0] sweep_hold;
  logic          sweep_abort;
  logic [SW-1:0] shift_amt;
  logic          shift_update;
  logic          sweep_active;
  logic [SW-1:0] sweep_step;
  logic          sweep_done;

  output_shift_ctrl_if #(.SHIFT_W(SW)) host_if ();

  output_shift_ctrl #(.SHIFT_W(SW), .HOLD_W(HW)) dut (
    .clk          (clk),
    .rst          (rst),
    .frame_start  (frame_start),
    .host         (host_if),
    .sweep_start  (sweep_start),
    .sweep_hold   (sweep_hold),
    .sweep_abort  (sweep_abort),
    .shift_amt    (shift_amt),
    .shift_update (shift_update),
    .sweep_active (sweep_active),
    .sweep_step   (sweep_step),
    .sweep_done   (sweep_done)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Entries are {frame index, sweep_step, shift_amt} of each shift_update pulse
  logic [23:0] rec_q[$];
  logic [23:0] exp_q[$];
  int mcount = 0;
  int done_cnt = 0;
  int nf = 0;
  int exp_done = 0;
  logic [SW-1:0] model_shift = '0;
  int sw_h;
  logic [SW-1:0] sw_saved;
  logic sw_ready;

  always @(negedge clk) begin
    if (shift_update) rec_q.push_back({16'(mcount), sweep_step, shift_amt});
    if (sweep_done) done_cnt++;
    if (frame_start) mcount++;
  end

  function automatic int seq_diff();
    int n;
    n = (rec_q.size() < exp_q.size()) ? rec_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (rec_q[i] !== exp_q[i]) return i;
    if (rec_q.size() != exp_q.size()) return n;
    return -1;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clear_q();
    rec_q.delete();
    exp_q.delete();
  endtask

  task automatic host_write(input logic [SW-1:0] v, input bit fs_same, input int gap);
    host_if.host_shift_valid = 1'b1;
    host_if.host_shift_data  = v;
    frame_start = fs_same;
    @(posedge clk); #1;
    host_if.host_shift_valid = 1'b0;
    frame_start = 1'b0;
    if (fs_same) nf++;
    idle(gap);
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    nf++;
    exp_q.push_back({16'(nf), 4'd0, v});
    model_shift = v;
    idle(1);
  endtask

  task automatic start_sweep(input logic [HW-1:0] hold_in, input bit with_host);
    sw_h = (hold_in == '0) ? 1 : int'(hold_in);
    sw_saved = model_shift;
    sweep_hold = hold_in;
    sweep_start = 1'b1;
    host_if.host_shift_valid = with_host;
    host_if.host_shift_data = SW'($urandom);
    #1 sw_ready = host_if.host_shift_ready;
    @(posedge clk); #1;
    sweep_start = 1'b0;
    host_if.host_shift_valid = 1'b0;
    sweep_hold = HW'($urandom);
  endtask

  // Step k of the sweep is expected on frame 1+k*h; the restore lands on frame 1+16*h
  task automatic sweep_frames(input int abort_frame, input bit abort_co, input int max_gap, input int stop_frame);
    int j;
    int k;
    bit fin;
    j = 0;
    fin = 1'b0;
    while (!fin && j < stop_frame && j < 200) begin
      idle($urandom_range(0, max_gap));
      if (abort_frame == j + 1 && !abort_co) begin
        sweep_abort = 1'b1;
        @(posedge clk); #1;
        sweep_abort = 1'b0;
        exp_q.push_back({16'(nf), 4'd0, sw_saved});
        fin = 1'b1;
      end else begin
        frame_start = 1'b1;
        sweep_abort = (abort_frame == j + 1);
        @(posedge clk); #1;
        frame_start = 1'b0;
        sweep_abort = 1'b0;
        nf++;
        j++;
        if (abort_frame == j) begin
          exp_q.push_back({16'(nf), 4'd0, sw_saved});
          fin = 1'b1;
        end else if (j == 1) begin
          exp_q.push_back({16'(nf), 4'd0, 4'd0});
        end else if ((j - 1) % sw_h == 0) begin
          k = (j - 1) / sw_h;
          if (k == MAX_SHIFT + 1) begin
            exp_q.push_back({16'(nf), 4'd0, sw_saved});
            exp_done++;
            fin = 1'b1;
          end else begin
            exp_q.push_back({16'(nf), 4'(k), 4'(k)});
          end
        end
      end
    end
    if (fin) model_shift = sw_saved;
    idle(2);
  endtask

  task automatic test_reset();
    host_if.host_shift_valid = 1'b1;
    host_if.host_shift_data = 4'd5;
    idle(3);
    tests_run++; if (shift_amt !== 4'd0) begin tests_failed++; $display("FAIL rst_shift_amt: got %0d expected 0", shift_amt); end
    tests_run++; if (shift_update !== 1'b0) begin tests_failed++; $display("FAIL rst_shift_update: got %b expected 0", shift_update); end
    tests_run++; if (sweep_active !== 1'b0) begin tests_failed++; $display("FAIL rst_sweep_active: got %b expected 0", sweep_active); end
    tests_run++; if (sweep_step !== 4'd0) begin tests_failed++; $display("FAIL rst_sweep_step: got %0d expected 0", sweep_step); end
    tests_run++; if (sweep_done !== 1'b0) begin tests_failed++; $display("FAIL rst_sweep_done: got %b expected 0", sweep_done); end
    tests_run++; if (host_if.host_shift_ready !== 1'b0) begin tests_failed++; $display("FAIL rst_ready: got %b expected 0", host_if.host_shift_ready); end
    rst = 1'b0;
    host_if.host_shift_valid = 1'b0;
    #1;
    tests_run++; if (host_if.host_shift_ready !== 1'b1) begin tests_failed++; $display("FAIL idle_ready: got %b expected 1", host_if.host_shift_ready); end
    idle(1);
    tests_run++; if (shift_amt !== 4'd0) begin tests_failed++; $display("FAIL post_rst_shift: got %0d expected 0", shift_amt); end
  endtask

  task automatic test_host_write();
    clear_q();
    host_if.host_shift_valid = 1'b1;
    host_if.host_shift_data = 4'd7;
    #1;
    tests_run++; if (host_if.host_shift_ready !== 1'b1) begin tests_failed++; $display("FAIL hw_ready_before: got %b expected 1", host_if.host_shift_ready); end
    @(posedge clk); #1;
    host_if.host_shift_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tests_run++;
      if (shift_amt !== 4'd0 || host_if.host_shift_ready !== 1'b0) begin
        tests_failed++; $display("FAIL hw_pending_c%0d: shift %0d ready %b expected 0 0", c, shift_amt, host_if.host_shift_ready);
      end
      idle(1);
    end
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    nf++;
    exp_q.push_back({16'(nf), 4'd0, 4'd7});
    model_shift = 4'd7;
    tests_run++; if (shift_amt !== 4'd7 || shift_update !== 1'b1) begin tests_failed++; $display("FAIL hw_apply: shift %0d update %b expected 7 1", shift_amt, shift_update); end
    tests_run++; if (host_if.host_shift_ready !== 1'b1) begin tests_failed++; $display("FAIL hw_ready_after: got %b expected 1", host_if.host_shift_ready); end
    idle(1);
    tests_run++; if (shift_update !== 1'b0) begin tests_failed++; $display("FAIL hw_update_width: got %b expected 0", shift_update); end
    tests_run++; if (seq_diff() >= 0) begin tests_failed++; $display("FAIL hw_seq: %0d updates expected %0d", rec_q.size(), exp_q.size()); end
  endtask

  task automatic test_sweep_same_cycle();
    int d0;
    int d;
    clear_q();
    d0 = done_cnt;
    host_write(4'd3, 1'b0, 1);
    start_sweep(16'd2, 1'b1);
    tests_run++; if (sw_ready !== 1'b0) begin tests_failed++; $display("FAIL sc_ready: got %b expected 0", sw_ready); end
    tests_run++; if (sweep_active !== 1'b1 || shift_amt !== 4'd3) begin tests_failed++; $display("FAIL sc_accept: active %b shift %0d expected 1 3", sweep_active, shift_amt); end
    sweep_frames(0, 1'b0, 2, 1000);
    d = seq_diff();
    tests_run++; if (d >= 0) begin tests_failed++; $display("FAIL sc_seq: first diff %0d, %0d updates expected %0d", d, rec_q.size(), exp_q.size()); end
    tests_run++; if (rec_q.size() != 18) begin tests_failed++; $display("FAIL sc_update_count: got %0d expected 18", rec_q.size()); end
    tests_run++; if (done_cnt - d0 != 1) begin tests_failed++; $display("FAIL sc_done: got %0d expected 1", done_cnt - d0); end
    tests_run++; if (shift_amt !== 4'd3 || sweep_active !== 1'b0) begin tests_failed++; $display("FAIL sc_final: shift %0d active %b expected 3 0", shift_amt, sweep_active); end
  endtask

  task automatic test_sweep_hold0();
    int d0;
    int d;
    clear_q();
    d0 = done_cnt;
    start_sweep(16'd0, 1'b0);
    tests_run++; if (sweep_active !== 1'b1) begin tests_failed++; $display("FAIL h0_active: got %b expected 1", sweep_active); end
    sweep_frames(0, 1'b0, 0, 1000);
    d = seq_diff();
    tests_run++; if (d >= 0) begin tests_failed++; $display("FAIL h0_seq: first diff %0d, %0d updates expected %0d", d, rec_q.size(), exp_q.size()); end
    tests_run++; if (done_cnt - d0 != 1 || sweep_active !== 1'b0) begin tests_failed++; $display("FAIL h0_done: done %0d active %b expected 1 0", done_cnt - d0, sweep_active); end
  endtask

  task automatic test_abort();
    int d0;
    int n0;
    clear_q();
    host_write(4'd9, 1'b0, 0);
    d0 = done_cnt;
    start_sweep(16'd1, 1'b0);
    sweep_frames(0, 1'b0, 1, 6);
    tests_run++; if (sweep_step !== 4'd5 || shift_amt !== 4'd5) begin tests_failed++; $display("FAIL ab_at5: step %0d shift %0d expected 5 5", sweep_step, shift_amt); end
    frame_start = 1'b1;
    sweep_abort = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    sweep_abort = 1'b0;
    nf++;
    exp_q.push_back({16'(nf), 4'd0, 4'd9});
    tests_run++; if (shift_amt !== 4'd9 || shift_update !== 1'b1) begin tests_failed++; $display("FAIL ab_restore: shift %0d update %b expected 9 1", shift_amt, shift_update); end
    tests_run++; if (sweep_active !== 1'b0 || sweep_step !== 4'd0) begin tests_failed++; $display("FAIL ab_exit: active %b step %0d expected 0 0", sweep_active, sweep_step); end
    idle(1);
    n0 = rec_q.size();
    for (int i = 0; i < 3; i++) begin
      frame_start = 1'b1; @(posedge clk); #1; frame_start = 1'b0; nf++;
      idle(1);
    end
    tests_run++; if (rec_q.size() != n0) begin tests_failed++; $display("FAIL ab_no_more: %0d updates expected %0d", rec_q.size(), n0); end
    tests_run++; if (done_cnt != d0) begin tests_failed++; $display("FAIL ab_no_done: got %0d expected %0d", done_cnt - d0, 0); end
    tests_run++; if (seq_diff() >= 0) begin tests_failed++; $display("FAIL ab_seq: %0d updates expected %0d", rec_q.size(), exp_q.size()); end
  endtask

  task automatic test_reset_mid_sweep();
    int h;
    clear_q();
    h = $urandom_range(1, 3);
    start_sweep(HW'(h), 1'b0);
    sweep_frames(0, 1'b0, 1, 1 + 10 * h);
    tests_run++; if (sweep_step !== 4'd10) begin tests_failed++; $display("FAIL rm_step10: got %0d expected 10", sweep_step); end
    rst = 1'b1;
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    nf++;
    tests_run++;
    if (shift_amt !== 4'd0 || shift_update !== 1'b0 || sweep_active !== 1'b0 || sweep_step !== 4'd0 || sweep_done !== 1'b0 || host_if.host_shift_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL rm_outputs: shift %0d upd %b act %b step %0d done %b rdy %b expected all 0", shift_amt, shift_update, sweep_active, sweep_step, sweep_done, host_if.host_shift_ready);
    end
    rst = 1'b0;
    #1;
    tests_run++; if (host_if.host_shift_ready !== 1'b1) begin tests_failed++; $display("FAIL rm_idle: ready %b expected 1", host_if.host_shift_ready); end
    model_shift = '0;
    idle(1);
    clear_q();
    host_write(4'd4, 1'b0, 2);
    tests_run++; if (shift_amt !== 4'd4) begin tests_failed++; $display("FAIL rm_host4: got %0d expected 4", shift_amt); end
    tests_run++; if (seq_diff() >= 0) begin tests_failed++; $display("FAIL rm_seq: %0d updates expected %0d", rec_q.size(), exp_q.size()); end
  endtask

  task automatic test_host_frame_same_cycle();
    host_if.host_shift_valid = 1'b1;
    host_if.host_shift_data = 4'd2;
    frame_start = 1'b1;
    @(posedge clk); #1;
    host_if.host_shift_valid = 1'b0;
    frame_start = 1'b0;
    nf++;
    tests_run++; if (shift_amt !== 4'd4 || shift_update !== 1'b0) begin tests_failed++; $display("FAIL fs_same_hold: shift %0d update %b expected 4 0", shift_amt, shift_update); end
    idle(2);
    tests_run++; if (shift_amt !== 4'd4) begin tests_failed++; $display("FAIL fs_same_wait: got %0d expected 4", shift_amt); end
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    nf++;
    model_shift = 4'd2;
    tests_run++; if (shift_amt !== 4'd2 || shift_update !== 1'b1) begin tests_failed++; $display("FAIL fs_same_apply: shift %0d update %b expected 2 1", shift_amt, shift_update); end
    idle(1);
  endtask

  task automatic test_random();
    int d0;
    int d;
    int op;
    int af;
    clear_q();
    d0 = done_cnt;
    exp_done = 0;
    for (int it = 0; it < 25; it++) begin
      op = $urandom_range(0, 2);
      if (op == 0) begin
        host_write(SW'($urandom), 1'($urandom), $urandom_range(0, 3));
      end else if (op == 1) begin
        start_sweep(HW'($urandom_range(0, 3)), 1'($urandom));
        sweep_frames(0, 1'b0, 2, 1000);
      end else begin
        start_sweep(HW'($urandom_range(0, 3)), 1'($urandom));
        af = $urandom_range(1, 16 * sw_h + 1);
        sweep_frames(af, 1'($urandom), 2, 1000);
      end
    end
    d = seq_diff();
    tests_run++; if (d >= 0) begin tests_failed++; $display("FAIL rnd_seq: first diff %0d got %h expected %h (%0d vs %0d updates)", d, (d < rec_q.size()) ? rec_q[d] : 24'h0, (d < exp_q.size()) ? exp_q[d] : 24'h0, rec_q.size(), exp_q.size()); end
    tests_run++; if (done_cnt - d0 != exp_done) begin tests_failed++; $display("FAIL rnd_done: got %0d expected %0d", done_cnt - d0, exp_done); end
    tests_run++; if (shift_amt !== model_shift || sweep_active !== 1'b0) begin tests_failed++; $display("FAIL rnd_final: shift %0d active %b expected %0d 0", shift_amt, sweep_active, model_shift); end
  endtask

  initial begin
    rst = 1'b1;
    frame_start = 1'b0;
    sweep_start = 1'b0;
    sweep_abort = 1'b0;
    sweep_hold = '0;
    host_if.host_shift_valid = 1'b0;
    host_if.host_shift_data = '0;
    test_reset();
    test_host_write();
    test_sweep_same_cycle();
    test_sweep_hold0();
    test_abort();
    test_reset_mid_sweep();
    test_host_frame_same_cycle();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/output_shift_ctrl.md
Name: output_shift_ctrl

Overview:
- Controller that owns the shift_amt input of the DAC output buffer. That buffer provides single-sample alignment of the 256-bit, 16-sample DAC word.
- Accepts shift-update requests from the host configuration path and runs an autonomous calibration sweep of all 16 shift values.
- Changes to shift_amt take effect only at frame boundaries, so no DAC frame ever contains a mid-frame alignment jump.
- Sits between the config/AXI register block and the output buffer, in the DAC clock domain.

Parameters:
SHIFT_W, 4, width of shift value; legal shifts 0..2^SHIFT_W-1.
HOLD_W, 16, width of the per-step sweep hold count, in frames.

Ports:
clk  in  1  DAC fabric clock; single clock domain.
rst  in  1  synchronous, active-high reset.
frame_start  in  1  one-cycle pulse coincident with the first DAC word of a frame.
host_shift_valid  in  1  host request valid.
host_shift_ready  out  1  controller can accept a host request.
host_shift_data  in  SHIFT_W  requested shift value.
sweep_start  in  1  one-cycle pulse that starts a calibration sweep.
sweep_hold  in  HOLD_W  frames to hold each sweep step; latched at sweep start.
sweep_abort  in  1  one-cycle pulse that aborts an active sweep.
shift_amt  out  SHIFT_W  registered shift value driven to the output buffer.
shift_update  out  1  one-cycle pulse in the first cycle a new shift_amt value is driven.
sweep_active  out  1  high from sweep acceptance until sweep exit.
sweep_step  out  SHIFT_W  current sweep step index.
sweep_done  out  1  one-cycle pulse on normal sweep completion.

Behaviour:
Reset values:
- Synchronous and active-high; applies from any state, including mid-sweep or with a host value pending.
- Outputs: shift_amt=0, shift_update=0, sweep_active=0, sweep_step=0, sweep_done=0, host_shift_ready=0 during reset; state=IDLE.
- Internal saved and pending registers cleared.

States:
- IDLE
- PENDING
- SWEEP_WAIT
- SWEEP_HOLD

host_shift_ready:
- Combinational: (state==IDLE) && !sweep_start.
- A transfer occurs when valid && ready.

IDLE:
- Host transfer: latch host_shift_data into pend, go to PENDING.
- sweep_start: wins over a simultaneous host_shift_valid, so no host transfer occurs that cycle.
  - Latch hold = max(sweep_hold, 1), where sweep_hold=0 is treated as 1.
  - Save the current shift_amt into saved.
  - Set sweep_active=1, go to SWEEP_WAIT.

PENDING:
- On frame_start, in the next cycle: shift_amt<=pend, shift_update=1 for one cycle, state IDLE.
- A frame_start in the same cycle as the host transfer does not apply the value; the next frame_start applies it.
- If pend equals the current shift_amt, shift_update still pulses.
- sweep_start is ignored outside IDLE.

SWEEP_WAIT:
- On frame_start: shift_amt<=0, sweep_step<=0, shift_update pulse, cnt<=hold, go to SWEEP_HOLD.

SWEEP_HOLD:
- Each frame_start decrements cnt.
- On a frame_start with cnt==1, and sweep_step < 2^SHIFT_W-1:
  - sweep_step and shift_amt increment by 1.
  - shift_update pulses; cnt<=hold.
- On a frame_start with cnt==1 and sweep_step == max:
  - shift_amt<=saved, shift_update pulses.
  - sweep_done pulses, sweep_active<=0, sweep_step<=0, state IDLE.
- Each step therefore persists exactly hold frames.
- Increment never wraps.

Abort:
- sweep_abort in SWEEP_WAIT or SWEEP_HOLD, in the next cycle:
  - shift_amt<=saved, shift_update pulses, sweep_active<=0, sweep_step<=0, state IDLE.
  - No sweep_done.
- Abort takes priority over a simultaneous frame_start step.
- Abort in IDLE or PENDING is ignored.

Output timing:
- All outputs except host_shift_ready are registered.
- shift_amt changes exactly one cycle after the qualifying frame_start.

Decomposition:
- Package output_ctrl_pkg:
  - state enum (IDLE, PENDING, SWEEP_WAIT, SWEEP_HOLD).
  - SHIFT_W default, MAX_SHIFT constant.
  - HOLD_W default.
- One sub-module, frame_hold_counter: loadable down-counter of HOLD_W bits, advanced by frame_start, flags count==1.
- FSM and output registers live in the top module.

Test Plan:
- Host write 7 in IDLE, first frame_start 5 cycles later -> shift_amt stays 0 until the cycle after frame_start, then 7; one shift_update pulse; host_shift_ready low in between.
- Same-cycle host_shift_valid and sweep_start, with shift_amt=3 -> no host transfer; sweep runs; shift_amt steps 0,1,…,15 every 2 frames (sweep_hold=2); returns to 3; 17 shift_update pulses; sweep_done once.
- sweep_hold=0 -> each step lasts 1 frame; sweep finishes after 17 frame_starts total (1 start plus 16 steps).
- sweep_abort at step 5, saved=9, coincident with frame_start -> shift_amt=9 next cycle; no step 6; no sweep_done; sweep_active=0.
- rst asserted during SWEEP_HOLD at step 10 -> next cycle all outputs at reset values and state IDLE; subsequent host write 4 applies normally.
- Host write 2 with a frame_start in the transfer cycle -> value not applied until the following frame_start.
